// File: rtl/hamming_pkg.sv
// Shared constants, data-position table and helpers for the extended Hamming (16,11) SECDED code.
package hamming_pkg;

    localparam int unsigned DATA_W = 11;
    localparam int unsigned CODE_W = 16;
    localparam int unsigned SYN_W  = 4;

    // Codeword position of data bit k, ascending; positions 0/1/2/4/8 carry parity.
    localparam logic [SYN_W-1:0] DATA_POS [DATA_W] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_SINGLE,
        ERR_DOUBLE
    } err_kind_t;

    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int unsigned k = 0; k < DATA_W; k++) begin
            d[k[3:0]] = code[DATA_POS[k]];
        end
        return d;
    endfunction

    function automatic err_kind_t classify(input logic [SYN_W-1:0] syn, input logic par);
        if (par) begin
            return ERR_SINGLE;
        end else if (syn != '0) begin
            return ERR_DOUBLE;
        end
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for a 16-bit extended Hamming codeword.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SYN_W-1:0]  syn,
    output logic              par
);

    always_comb begin
        syn = '0;
        for (int unsigned i = 1; i < CODE_W; i++) begin
            if (code[i[3:0]]) begin
                syn = syn ^ i[3:0];
            end
        end
        par = ^code;
    end

endmodule

// File: rtl/hamming_decoder_secded.sv
// Two-stage valid/ready SECDED decoder for extended Hamming (16,11) codewords.
// Optional saturating error counters are built when HAMMING_DEC_COUNTERS_EN is defined.
module hamming_decoder_secded
    import hamming_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] c_h,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] data_out,
    output logic        err_single,
    output logic        err_double,
    output logic [3:0]  syndrome
`ifdef HAMMING_DEC_COUNTERS_EN
    ,
    input  logic        cnt_clr,
    output logic [15:0] cnt_single,
    output logic [15:0] cnt_double
`endif
);

    logic              advance;
    logic [SYN_W-1:0]  syn_c;
    logic              par_c;

    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic [SYN_W-1:0]  s1_syn;
    logic              s1_par;

    err_kind_t         kind;
    logic [CODE_W-1:0] fixed_code;
    logic [DATA_W-1:0] dec_data;

    hamming_syndrome u_syndrome (
        .code (c_h),
        .syn  (syn_c),
        .par  (par_c)
    );

    assign advance  = !out_valid || out_ready;
    // Held low while reset is asserted so every output reads 0 during reset.
    assign in_ready = advance && rst_n;

    always_comb begin
        kind       = classify(s1_syn, s1_par);
        fixed_code = s1_code;
        // s=0 with p=1 flips position 0, the overall parity bit, leaving data untouched.
        if (kind == ERR_SINGLE) begin
            fixed_code[s1_syn] = ~s1_code[s1_syn];
        end
        dec_data = extract_data(fixed_code);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_code    <= '0;
            s1_syn     <= '0;
            s1_par     <= 1'b0;
            out_valid  <= 1'b0;
            data_out   <= '0;
            err_single <= 1'b0;
            err_double <= 1'b0;
            syndrome   <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_code <= c_h;
                s1_syn  <= syn_c;
                s1_par  <= par_c;
            end
            if (s1_valid) begin
                data_out   <= dec_data;
                err_single <= (kind == ERR_SINGLE);
                err_double <= (kind == ERR_DOUBLE);
                syndrome   <= s1_syn;
            end
        end
    end

`ifdef HAMMING_DEC_COUNTERS_EN
    logic out_xfer;

    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (cnt_clr) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (out_xfer) begin
            if (err_single && (cnt_single != '1)) begin
                cnt_single <= cnt_single + 16'd1;
            end
            if (err_double && (cnt_double != '1)) begin
                cnt_double <= cnt_double + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hamming_decoder_secded.sv
// Scoreboard bench for hamming_decoder_secded; counter checks compile in with HAMMING_DEC_COUNTERS_EN.
module tb_hamming_decoder_secded;

    typedef struct packed {
        logic [10:0] d;
        logic        es;
        logic        ed;
        logic [3:0]  syn;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] c_h;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] data_out;
    logic        err_single;
    logic        err_double;
    logic [3:0]  syndrome;
`ifdef HAMMING_DEC_COUNTERS_EN
    logic        cnt_clr;
    logic [15:0] cnt_single;
    logic [15:0] cnt_double;
`endif

    int unsigned total;
    int unsigned bad;
    int unsigned n_out;
    exp_t        sb[$];

    hamming_decoder_secded dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .c_h        (c_h),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .err_single (err_single),
        .err_double (err_double),
        .syndrome   (syndrome)
`ifdef HAMMING_DEC_COUNTERS_EN
        ,
        .cnt_clr    (cnt_clr),
        .cnt_single (cnt_single),
        .cnt_double (cnt_double)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void calc(input logic [15:0] w, output logic [3:0] s, output logic p);
        s = 4'd0;
        p = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (w[i]) begin
                p = ~p;
                s = s ^ 4'(i);
            end
        end
    endfunction

    function automatic exp_t model(input logic [15:0] w);
        logic [3:0]  s;
        logic        p;
        logic [15:0] f;
        exp_t        e;
        calc(w, s, p);
        e     = '0;
        e.syn = s;
        f     = w;
        if (p) begin
            e.es = 1'b1;
            f[s] = ~f[s];
        end else if (s != 4'd0) begin
            e.ed = 1'b1;
        end
        e.d = {f[15], f[14], f[13], f[12], f[11], f[10], f[9], f[7], f[6], f[5], f[3]};
        return e;
    endfunction

    // Turns a random word into a valid codeword, then flips nerr distinct bits.
    function automatic logic [15:0] make_word(input logic [15:0] r, input int nerr);
        logic [3:0]  s;
        logic        p;
        logic [15:0] w;
        int          a;
        int          b;
        w = r;
        calc(w, s, p);
        w[s] = w[s] ^ (s != 4'd0);
        calc(w, s, p);
        w[0] = w[0] ^ p;
        a = int'($urandom_range(15, 0));
        b = (a + 1 + int'($urandom_range(14, 0))) % 16;
        if (nerr >= 1) w[a] = ~w[a];
        if (nerr >= 2) w[b] = ~w[b];
        return w;
    endfunction

    task automatic directed(input string tag, input logic [15:0] w, input logic [10:0] d,
                            input logic es, input logic ed, input logic [3:0] syn);
        @(posedge clk); #1;
        c_h      = w;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 0);
        @(posedge clk); #1;
        check({tag, "_lat2"}, out_valid, 1);
        check({tag, "_data"}, data_out, d);
        check({tag, "_es"}, err_single, es);
        check({tag, "_ed"}, err_double, ed);
        check({tag, "_syn"}, syndrome, syn);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [24:0] held;
        logic        stall_prev;
        logic [15:0] words[4];
        int          idx;
        int          cyc;
        int          out_before;
        logic        acc;
`ifdef HAMMING_DEC_COUNTERS_EN
        logic [15:0] exp_cs;
        logic [15:0] exp_cd;
        exp_cs = '0;
        exp_cd = '0;
        cnt_clr = 1'b0;
`endif
        total = 0;
        bad = 0;
        n_out = 0;
        stall_prev = 1'b0;
        held = '0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        c_h = '0;
        out_ready = 1'b1;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (!rst_n) begin
                    sb.delete();
                    stall_prev = 1'b0;
`ifdef HAMMING_DEC_COUNTERS_EN
                    exp_cs = '0;
                    exp_cd = '0;
`endif
                end else begin
`ifdef HAMMING_DEC_COUNTERS_EN
                    check("cnt_single", cnt_single, exp_cs);
                    check("cnt_double", cnt_double, exp_cd);
`endif
                    if (stall_prev) begin
                        check("stall_valid", out_valid, 1);
                        check("stall_hold", {data_out, err_single, err_double, syndrome}, held);
                    end
                    if (in_valid && in_ready) sb.push_back(model(c_h));
                    e = '0;
                    if (out_valid && out_ready) begin
                        n_out++;
                        if (sb.size() == 0) begin
                            check("unexpected_out", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            check("sb_result", {data_out, err_single, err_double, syndrome}, e);
                        end
                    end
`ifdef HAMMING_DEC_COUNTERS_EN
                    if (cnt_clr) begin
                        exp_cs = '0;
                        exp_cd = '0;
                    end else if (out_valid && out_ready) begin
                        if (e.es && exp_cs != 16'hFFFF) exp_cs = exp_cs + 16'd1;
                        if (e.ed && exp_cd != 16'hFFFF) exp_cd = exp_cd + 16'd1;
                    end
`endif
                    stall_prev = out_valid && !out_ready;
                    held = {data_out, err_single, err_double, syndrome};
                end
            end
        join_none

        // Reset state
        @(posedge clk); #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_outputs", {data_out, err_single, err_double, syndrome}, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Known vectors
        directed("clean", 16'hD4DB, 11'h6AD, 1'b0, 1'b0, 4'd0);
        directed("data_err", 16'hD49B, 11'h6AD, 1'b1, 1'b0, 4'd6);
`ifdef HAMMING_DEC_COUNTERS_EN
        check("cnt_single_one", cnt_single, 1);
`endif
        directed("par_err", 16'hD4DA, 11'h6AD, 1'b1, 1'b0, 4'd0);
        directed("dbl_err", 16'hD0D3, 11'h68C, 1'b0, 1'b1, 4'd9);
`ifdef HAMMING_DEC_COUNTERS_EN
        check("cnt_double_one", cnt_double, 1);
`endif

        // Random traffic with random backpressure and 0/1/2 bit errors
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(9, 0) < 8);
            out_ready = ($urandom_range(3, 0) != 0);
            c_h       = make_word(16'($urandom), int'($urandom_range(2, 0)));
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("rand_drain", sb.size(), 0);

        // Backpressure: four words, consumer stalled for three cycles
        words[0] = 16'hD4DB;
        words[1] = 16'hD49B;
        words[2] = 16'hD0D3;
        words[3] = make_word(16'h1234, 1);
        out_before = int'(n_out);
        idx = 0;
        out_ready = 1'b0;
        for (cyc = 0; cyc < 30 && idx < 4; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 3) out_ready = 1'b1;
            in_valid = 1'b1;
            c_h = words[idx];
            @(negedge clk);
            acc = in_valid && in_ready;
            if (cyc == 2) check("bp_in_ready_low", in_ready, 0);
            if (acc) idx++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("bp_drain", sb.size(), 0);
        check("bp_count", n_out - out_before, 4);

        // Reset with both stages full
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            c_h = words[i+1];
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_before_rst", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_outputs", {data_out, err_single, err_double, syndrome}, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        out_before = int'(n_out);
        repeat (6) @(posedge clk);
        #1;
        check("no_stale_out", n_out - out_before, 0);
`ifdef HAMMING_DEC_COUNTERS_EN
        check("rst_cnt_single", cnt_single, 0);
        check("rst_cnt_double", cnt_double, 0);
        c_h = 16'hD49B;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("clr_out_valid", out_valid, 1);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("clr_priority", cnt_single, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hamming_decoder_secded.md
HAMMING_DECODER_SECDED -- requirements
Module: hamming_decoder_secded

Interface
REQ-001 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-002 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 Port in_valid, input, 1, a codeword is presented on c_h.
REQ-004 Port in_ready, output, 1, the block can accept a codeword this cycle.
REQ-005 Port c_h, input, 16, extended Hamming codeword; c_h[i] is position i, parity at positions 0/1/2/4/8.
REQ-006 Port out_valid, output, 1, a decoded result is presented.
REQ-007 Port out_ready, input, 1, the consumer accepts the result this cycle.
REQ-008 Port data_out, output, 11, corrected data; bit k is taken from data positions 3,5,6,7,9,10,11,12,13,14,15 in ascending order.
REQ-009 Port err_single, output, 1, a single-bit error was corrected.
REQ-010 Port err_double, output, 1, an uncorrectable double-bit error was detected.
REQ-011 Port syndrome, output, 4, Hamming syndrome of the result.
REQ-012 Ports cnt_clr (input, 1), cnt_single (output, 16), cnt_double (output, 16): error counters and their synchronous clear; present only under REQ-027.

Function
REQ-013 Syndrome s SHALL be the XOR of the indices i in 1..15 for which c_h[i]=1; overall parity p SHALL be the XOR of all 16 bits.
REQ-014 Classification SHALL be as follows.
- s=0, p=0: no error.
- p=1: single error at position s. For s=0 only the overall parity bit is flipped, and the data is unaffected.
- s!=0, p=0: double error.
REQ-015 On a single error, bit s SHALL be inverted before data extraction; err_single=1, err_double=0.
REQ-016 On a double error, data_out SHALL be the uncorrected extracted bits; err_double=1, err_single=0.
REQ-017 The pipeline SHALL have two register stages: stage 1 registers c_h, s and p; stage 2 registers data_out, the flags and syndrome.
REQ-018 Latency SHALL be 2 cycles from the accepting edge to out_valid=1 when out_ready is held high.
REQ-019 Throughput SHALL be one codeword per cycle when out_ready is held high.
REQ-020 A transfer SHALL occur only on a cycle where valid=1 and ready=1.
REQ-021 Pipeline advance: advance = !out_valid || out_ready; in_ready = advance.
- Both stages SHALL move only when advance=1.
- in_ready SHALL NOT depend combinationally on in_valid.
REQ-022 While out_valid=1 and out_ready=0, all outputs SHALL hold stable, and no accepted codeword SHALL be lost or duplicated.
REQ-023 Bubbles (in_valid=0 on an advancing cycle) SHALL propagate as invalid stage slots.

Reset
REQ-024 With rst_n=0, all outputs SHALL be 0 and both stage valid flags SHALL clear; this applies mid-operation too, discarding in-flight codewords.
REQ-025 After rst_n deasserts, in_ready SHALL be 1 on the first cycle.

Configuration
REQ-026 Macro HAMMING_DEC_COUNTERS_EN SHALL gate the error-counter feature.
REQ-027 With HAMMING_DEC_COUNTERS_EN defined, the counters SHALL behave as follows.
- cnt_single and cnt_double increment by 1 on each output transfer (out_valid and out_ready both 1) with the matching flag.
- Both saturate at 16'hFFFF and reset to 0.
- cnt_clr=1 zeroes both on the next edge and takes priority over a simultaneous increment.
REQ-028 Without HAMMING_DEC_COUNTERS_EN, the cnt_clr, cnt_single and cnt_double ports and all counter logic SHALL be absent; the decode behaviour SHALL be otherwise identical.

Structure
REQ-029 Package hamming_pkg SHALL hold the following.
- Constants DATA_W=11, CODE_W=16, SYN_W=4.
- The data-position table.
- An enum err_kind_t {ERR_NONE, ERR_SINGLE, ERR_DOUBLE}.
REQ-030 Purely combinational sub-module hamming_syndrome SHALL compute s and p from a 16-bit codeword, and SHALL be reusable by the encoder bench.

Verification
REQ-031 Clean word: c_h=16'hD4DB, out_ready=1 -> data_out=11'h6AD two cycles later; err_single=0, err_double=0, syndrome=0.
REQ-032 Data-bit error: c_h=16'hD49B (bit 6 flipped) -> data_out=11'h6AD, err_single=1, syndrome=6; the counters build shows cnt_single=1.
REQ-033 Parity-bit error: c_h=16'hD4DA (bit 0 flipped) -> data_out=11'h6AD, err_single=1, syndrome=0.
REQ-034 Double error: c_h=16'hD0D3 (bits 3 and 10 flipped) -> err_double=1, err_single=0, syndrome=9, data_out is the uncorrected extraction; the counters build shows cnt_double=1.
REQ-035 Backpressure: stream 4 words with out_ready=0 for 3 cycles then 1.
- in_ready drops once both stages are full.
- Outputs hold during the stall.
- All 4 results emerge in order with none lost or duplicated.
REQ-036 Reset during traffic: assert rst_n=0 with both stages full -> out_valid=0 immediately; after release, nothing stale is emitted; the counters build shows counters at 0, and cnt_clr on the same edge as an error transfer leaves the counter at 0.
